// File: rtl/mem_io_bridge_pkg.sv
// Shared address-map constants and status layout for the memory/IO bridge.
// Processor test programs import this package too, so keep the encodings stable.
package mem_io_bridge_pkg;

  localparam logic [3:0] REG_RAM = 4'h0;
  localparam logic [3:0] REG_LED = 4'h1;
  localparam logic [3:0] REG_SW  = 4'h3;
  localparam logic [3:0] REG_TX  = 4'h4;

  // ADDR[0] selects within the TX region
  localparam logic TX_SUB_DATA   = 1'b0;
  localparam logic TX_SUB_STATUS = 1'b1;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef struct packed {
    logic ovf;
    logic full;
    logic empty;
  } tx_status_t;

  typedef struct packed {
    logic [3:0] region;
    logic       sub;
    logic       wr;
  } bus_req_t;

  function automatic logic [15:0] status_word(input tx_status_t st);
    logic [15:0] w;
    w = '0;
    w[ST_EMPTY] = st.empty;
    w[ST_FULL]  = st.full;
    w[ST_OVF]   = st.ovf;
    return w;
  endfunction

endpackage

// File: rtl/mem_io_bridge_sync_fifo.sv
// Small synchronous FIFO for the TX channel; head is driven from storage flops.
// A pop on an empty FIFO is ignored, and a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Processor-side bus bridge: decodes ADDR[15:12] to RAM, LEDs, switches and a TX FIFO,
// returning DIN exactly one cycle after ADDR to match the processor's memory wait cycle.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int RAM_AW     = 12,
  parameter int LED_W      = 10,
  parameter int SW_W       = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       DOUT,
  input  logic              W,
  output logic [15:0]       DIN,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  output logic [LED_W-1:0]  LEDR,
  input  logic [SW_W-1:0]   SW,
  output logic [15:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  bus_req_t        req;
  logic            tx_push, tx_pop, tx_full, tx_empty, tx_drop, status_rd;
  logic [CW-1:0]   tx_count;
  logic [SW_W-1:0] sw_meta, sw_sync;
  logic            ovf;
  logic [15:0]     io_rd, io_rd_q;
  logic [3:0]      region_q;
  tx_status_t      st;

  assign req = '{region: ADDR[15:12], sub: ADDR[0], wr: W};

  assign mem_addr  = ADDR[RAM_AW-1:0];
  assign mem_wdata = DOUT;
  assign mem_we    = req.wr & (req.region == REG_RAM);

  assign tx_push   = req.wr & (req.region == REG_TX) & (req.sub == TX_SUB_DATA);
  assign tx_pop    = tx_valid & tx_ready;
  assign tx_drop   = tx_push & ~tx_pop & (tx_count == FULL_CNT);
  // Writes never touch read-side state, so only a W=0 access counts as a status read
  assign status_rd = ~req.wr & (req.region == REG_TX) & (req.sub == TX_SUB_STATUS);
  assign tx_valid  = ~tx_empty;

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .Clock (Clock),
    .Resetn(Resetn),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (DOUT),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_data)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      LEDR    <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      ovf     <= 1'b0;
    end else begin
      if (req.wr && req.region == REG_LED) LEDR <= DOUT[LED_W-1:0];
      sw_meta <= SW;
      sw_sync <= sw_meta;
      // A drop in the same cycle as a status read must survive the clear
      if (tx_drop)        ovf <= 1'b1;
      else if (status_rd) ovf <= 1'b0;
    end
  end

  always_comb begin
    st    = '{ovf: ovf, full: tx_full, empty: tx_empty};
    io_rd = '0;
    case (req.region)
      REG_LED: io_rd[LED_W-1:0] = LEDR;
      REG_SW:  io_rd[SW_W-1:0]  = sw_sync;
      REG_TX:  if (req.sub == TX_SUB_STATUS) io_rd = status_word(st);
      default: io_rd = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      region_q <= REG_RAM;
      io_rd_q  <= '0;
    end else begin
      region_q <= req.region;
      io_rd_q  <= io_rd;
    end
  end

  // RAM supplies its own registered data, so it bypasses io_rd_q
  assign DIN = (region_q == REG_RAM) ? mem_rdata : io_rd_q;

endmodule
